// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: registers one legal request, runs a single bus
// access with an active-low acknowledge, aligns load data and stalls the pipe.
module lsu_bus_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        err,
  output logic        MREQ,
  output logic        WRITE,
  output logic [1:0]  SIZE,
  output logic [31:0] DAD,
  input  logic        ACKD_n,
  inout  wire  [31:0] DDT
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [31:0]     wdata_q;
  logic            unsigned_q;
  logic            legal;
  logic            accept, reject, done, timed_out;
  logic [31:0]     shifted, ld_aligned;

  always_comb begin
    case (req_size)
      2'b00:   legal = (req_addr[1:0] == 2'b00);
      2'b01:   legal = ~req_addr[0];
      2'b10:   legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nx  = state;
    stall     = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    done      = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (legal) begin
            accept   = 1'b1;
            stall    = 1'b1;
            state_nx = ACCESS;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ACCESS: begin
        stall = 1'b1;
        // Acknowledge takes priority over a timeout on the same edge.
        if (!ACKD_n) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else if (TIMEOUT != 0 && int'(cnt) + 1 == TIMEOUT) begin
          timed_out = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Little-endian lane select from the latched address, then extension.
  always_comb begin
    shifted = DDT >> {DAD[1:0], 3'b000};
    case (SIZE)
      2'b10:   ld_aligned = unsigned_q ? {24'b0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ld_aligned = unsigned_q ? {16'b0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_aligned = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MREQ       <= 1'b0;
      WRITE      <= 1'b0;
      SIZE       <= 2'b00;
      DAD        <= 32'b0;
      wdata_q    <= 32'b0;
      unsigned_q <= 1'b0;
      cnt        <= '0;
      ld_valid   <= 1'b0;
      ld_data    <= 32'b0;
      err        <= 1'b0;
    end else begin
      MREQ     <= (state_nx == ACCESS);
      ld_valid <= done & ~WRITE;
      err      <= reject | timed_out;
      if (accept) begin
        WRITE      <= req_write;
        SIZE       <= req_size;
        DAD        <= req_addr;
        unsigned_q <= req_unsigned;
        cnt        <= '0;
        case (req_size)
          2'b10:   wdata_q <= {4{req_wdata[7:0]}};
          2'b01:   wdata_q <= {2{req_wdata[15:0]}};
          default: wdata_q <= req_wdata;
        endcase
      end else if (state == ACCESS && ACKD_n) begin
        cnt <= cnt + 1'b1;
      end
      if (done && !WRITE) ld_data <= ld_aligned;
    end
  end

  assign DDT = (state == ACCESS && WRITE) ? wdata_q : 'z;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Bench for lsu_bus_ctrl: directed and random load/store transactions compared
// against a transaction-level model of stall length, bus activity and results.
module tb_lsu_bus_ctrl;

  localparam int TIMEOUT = 15;
  localparam int WINDOW  = 22;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_unsigned, ACKD_n;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, ld_valid, err, MREQ, WRITE;
  logic [1:0]  SIZE;
  logic [31:0] ld_data, DAD;
  wire  [31:0] DDT;
  logic        mem_drive;
  logic [31:0] mem_data;

  int total = 0;
  int bad   = 0;

  assign DDT = mem_drive ? mem_data : 'z;

  lsu_bus_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data), .err(err),
    .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE), .DAD(DAD),
    .ACKD_n(ACKD_n), .DDT(DDT)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [1:0] size, input logic [31:0] addr);
    case (size)
      2'd0:    return (addr % 4) == 0;
      2'd1:    return (addr % 2) == 0;
      2'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] rd);
    longint v;
    int     bits;
    int     lane;
    bits = (size == 2'd2) ? 8 : (size == 2'd1) ? 16 : 32;
    lane = int'(addr % 4);
    v = (longint'(rd) >> (8 * lane)) & ((longint'(1) << bits) - 1);
    if (!uns && bits < 32 && v >= (longint'(1) << (bits - 1)))
      v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  function automatic logic [31:0] exp_store(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd2) return (wd % 256) * 32'h0101_0101;
    if (size == 2'd1) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  // One request, then a fixed observation window. ACKD_n goes low in the
  // (waits+1)-th cycle that MREQ is seen high; waits >= TIMEOUT never acks.
  task automatic run_op(input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int waits, input logic [31:0] rd);
    int          n_stall = 0, n_mreq = 0, n_ldv = 0, n_err = 0;
    int          ldv_cyc = -1, err_cyc = -1, ack_cyc = -1, last_mreq = -1;
    int          exp_acc;
    bit          legal, first;
    logic [31:0] got_ld = '0, got_dad = '0, got_ddt = '0;
    logic        got_wr = 1'b0;
    logic [1:0]  got_size = 2'b00;

    legal   = is_legal(size, addr);
    exp_acc = !legal ? 0 : (waits < TIMEOUT) ? waits + 1 : TIMEOUT;

    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; ACKD_n = 1'b1; mem_drive = 1'b0;
    #1 if (stall) n_stall++;

    for (int c = 1; c <= WINDOW; c++) begin
      @(posedge clk); #1;
      first = 1'b0;
      // Junk on the request port while the access is outstanding must be ignored.
      if (c <= exp_acc) begin
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_size  = 2'($urandom_range(0, 3));
        req_addr  = $urandom;
        req_wdata = $urandom;
      end else begin
        req_valid = 1'b0;
      end
      ACKD_n = 1'b1; mem_drive = 1'b0;
      if (MREQ) begin
        n_mreq++;
        last_mreq = c;
        if (n_mreq == 1) begin
          first = 1'b1; got_dad = DAD; got_wr = WRITE; got_size = SIZE;
        end
        if (n_mreq == waits + 1) begin
          ACKD_n = 1'b0; ack_cyc = c;
          if (!wr) begin mem_drive = 1'b1; mem_data = rd; end
        end
      end
      if (ld_valid) begin n_ldv++; ldv_cyc = c; got_ld = ld_data; end
      if (err) begin n_err++; err_cyc = c; end
      #1;
      if (stall) n_stall++;
      if (first) got_ddt = DDT;
    end
    ACKD_n = 1'b1; mem_drive = 1'b0;

    if (!legal) begin
      check("illegal_stall", 32'(n_stall), 32'd0);
      check("illegal_mreq",  32'(n_mreq),  32'd0);
      check("illegal_ldv",   32'(n_ldv),   32'd0);
      check("illegal_err",   32'(n_err),   32'd1);
      check("illegal_err_cycle", 32'(err_cyc), 32'd1);
    end else if (waits < TIMEOUT) begin
      check("stall_cycles", 32'(n_stall), 32'(waits + 2));
      check("mreq_cycles",  32'(n_mreq),  32'(waits + 1));
      check("err_count",    32'(n_err),   32'd0);
      check("bus_dad",      got_dad,      addr);
      check("bus_write",    32'(got_wr),  32'(wr));
      check("bus_size",     32'(got_size), 32'(size));
      if (wr) begin
        check("store_ddt", got_ddt, exp_store(size, wd));
        check("store_ldv", 32'(n_ldv), 32'd0);
      end else begin
        check("load_ldv",       32'(n_ldv),   32'd1);
        check("load_ldv_cycle", 32'(ldv_cyc), 32'(ack_cyc + 1));
        check("load_data",      got_ld,       exp_load(size, uns, addr, rd));
      end
    end else begin
      check("tmo_stall", 32'(n_stall), 32'(TIMEOUT + 1));
      check("tmo_mreq",  32'(n_mreq),  32'(TIMEOUT));
      check("tmo_ldv",   32'(n_ldv),   32'd0);
      check("tmo_err",   32'(n_err),   32'd1);
      check("tmo_err_cycle", 32'(err_cyc), 32'(last_mreq + 1));
    end
  endtask

  initial begin
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic        r_wr;

    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; ACKD_n = 1'b1;
    mem_drive = 1'b0; mem_data = '0;
    #3;
    check("rst_mreq",  32'(MREQ),     32'd0);
    check("rst_write", 32'(WRITE),    32'd0);
    check("rst_size",  32'(SIZE),     32'd0);
    check("rst_dad",   DAD,           32'd0);
    check("rst_stall", 32'(stall),    32'd0);
    check("rst_ldv",   32'(ld_valid), 32'd0);
    check("rst_lddata", ld_data,      32'd0);
    check("rst_err",   32'(err),      32'd0);
    #9 rst = 1'b1;

    run_op(1'b0, 2'd0, 1'b0, 32'h0000_1004, 32'h0, 0, 32'h8000_00F0);
    run_op(1'b0, 2'd2, 1'b0, 32'h0000_1003, 32'h0, 0, 32'h80AA_BBCC);
    run_op(1'b0, 2'd2, 1'b1, 32'h0000_1003, 32'h0, 0, 32'h80AA_BBCC);
    run_op(1'b0, 2'd1, 1'b0, 32'h0000_1002, 32'h0, 0, 32'h80AA_BBCC);
    run_op(1'b1, 2'd2, 1'b0, 32'h0000_2001, 32'h1234_5678, 3, 32'h0);
    run_op(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'hCAFE_BABE, 1, 32'h0);
    run_op(1'b0, 2'd0, 1'b0, 32'h0000_1002, 32'h0, 0, 32'h0);
    run_op(1'b0, 2'd3, 1'b0, 32'h0000_1000, 32'h0, 0, 32'h0);
    run_op(1'b0, 2'd0, 1'b0, 32'h0000_1008, 32'h0, 99, 32'h0);
    run_op(1'b0, 2'd1, 1'b1, 32'h0000_100A, 32'h0, TIMEOUT - 1, 32'hBEEF_1234);

    // Asynchronous reset in the middle of a waiting load.
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd0; req_addr = 32'h0000_3000;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_mreq", 32'(MREQ), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst_mreq",  32'(MREQ),     32'd0);
    check("midrst_stall", 32'(stall),    32'd0);
    check("midrst_dad",   DAD,           32'd0);
    check("midrst_ldv",   32'(ld_valid), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    ACKD_n = 1'b0;
    @(posedge clk); #1;
    check("postrst_ldv",  32'(ld_valid), 32'd0);
    check("postrst_mreq", 32'(MREQ),     32'd0);
    ACKD_n = 1'b1;
    run_op(1'b0, 2'd0, 1'b0, 32'h0000_3004, 32'h0, 2, 32'h1357_9BDF);

    for (int i = 0; i < 20; i++) begin
      r_size = 2'($urandom_range(0, 3));
      r_wr   = 1'($urandom_range(0, 1));
      r_addr = 32'h0000_4000 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0 && r_size == 2'd0) r_addr = r_addr & 32'hFFFF_FFFC;
      run_op(r_wr, r_size, 1'($urandom_range(0, 1)), r_addr, $urandom,
             int'($urandom_range(0, 4)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
